// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display. Holds a double-buffered frame of BCD
// digits, lights one digit per scan slot with active-low anodes, and opens
// every slot with an all-off guard interval to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module sevenseg_scan_mux #(
   parameter int N_DIGITS        = 4,
   parameter int TICKS_PER_DIGIT = 12500,
   parameter int GUARD_TICKS     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   output logic [3:0]            digit,
   output logic                  blank,
   output logic [N_DIGITS-1:0]   an_n,
   output logic                  frame_start
);

   localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef logic [N_DIGITS-1:0][3:0] frame_t;

   logic [TW-1:0] tick;
   logic [IW-1:0] idx;
   frame_t        shadow;
   frame_t        staging;
   frame_t        din;
   logic          pending;

   logic          last_tick;
   logic          last_idx;
   logic          wrap;
   logic          in_guard;
   logic [N_DIGITS-1:0] sup;

   assign din       = digits_in;
   assign last_tick = (tick == TW'(TICKS_PER_DIGIT - 1));
   assign last_idx  = (idx == IW'(N_DIGITS - 1));
   // A wrap is the edge at which the registered idx returns to 0 by counting.
   assign wrap      = enable && last_tick && last_idx;
   assign in_guard  = (32'(tick) < GUARD_TICKS);

`ifdef LEADING_ZERO_BLANK_EN
   // Leading-zero run computed from the top digit down on the displayed frame,
   // so suppression cannot change partway through a frame. Digit 0 always shows.
   logic [N_DIGITS-1:0] zrun;
   assign zrun[N_DIGITS-1] = (shadow[N_DIGITS-1] == 4'd0);
   for (genvar i = N_DIGITS - 2; i >= 0; i--) begin : g_zrun
      assign zrun[i] = zrun[i+1] && (shadow[i] == 4'd0);
   end
   assign sup = {zrun[N_DIGITS-1:1], 1'b0};
`else
   assign sup = '0;
`endif

   // Scan position counter plus staging/shadow double buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= '0;
         idx     <= '0;
         shadow  <= '0;
         staging <= '0;
         pending <= 1'b0;
      end else begin
         if (enable) begin
            if (last_tick) begin
               tick <= '0;
               idx  <= last_idx ? '0 : idx + 1'b1;
            end else begin
               tick <= tick + 1'b1;
            end
         end
         if (load) staging <= din;
         if (wrap) begin
            // A load landing on the wrap edge bypasses staging entirely.
            pending <= 1'b0;
            if (load)         shadow <= din;
            else if (pending) shadow <= staging;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   // Registered display outputs, one cycle behind tick/idx/shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_n        <= '1;
         blank       <= 1'b1;
         digit       <= 4'd0;
         frame_start <= 1'b0;
      end else begin
         digit       <= shadow[idx];
         frame_start <= wrap;
         if (!enable || in_guard) begin
            an_n  <= '1;
            blank <= 1'b1;
         end else begin
            an_n  <= ~(N_DIGITS'(1) << idx);
            blank <= sup[idx];
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux with N_DIGITS=4, TICKS_PER_DIGIT=8, GUARD_TICKS=2.
// Expected per-slot records are queued when digits are loaded and popped
// when the corresponding frame is scanned out.
module tb_sevenseg_scan_mux;

   localparam int N = 4;
   localparam int T = 8;
   localparam int G = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0;
   logic [3:0]  digit;
   logic        blank;
   logic [3:0]  an_n;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sevenseg_scan_mux #(
      .N_DIGITS(N), .TICKS_PER_DIGIT(T), .GUARD_TICKS(G)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
      .digit(digit), .blank(blank), .an_n(an_n), .frame_start(frame_start)
   );

   typedef struct {
      logic [3:0] digit;
      logic       blank;
   } slot_t;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  lzb;   // blank mask expected when leading-zero blanking is built in
   } vec_t;

   slot_t sbq[$];
   vec_t  tab[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [3:0] bmask(input logic [3:0] lzb);
`ifdef LEADING_ZERO_BLANK_EN
      return lzb;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [3:0] lzb);
      logic [3:0] m;
      slot_t r;
      m = bmask(lzb);
      for (int s = 0; s < N; s++) begin
         r.digit = v[4*s +: 4];
         r.blank = m[s];
         sbq.push_back(r);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] lzb);
      load = 1'b1;
      digits_in = v;
      push_frame(v, lzb);
      step();
      load = 1'b0;
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_start && n < 200);
      chk("frame_start_seen", frame_start, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an_n"}, an_n, 4'hF);
      chk({tag, "_blank"}, blank, 1);
      chk({tag, "_digit"}, digit, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, "_an_n"}, an_n, 4'hF);
      chk({tag, "_blank"}, blank, 1);
      chk({tag, "_frame_start"}, frame_start, 0);
   endtask

   // Scan out one full frame starting just after a frame_start sample.
   // Optional: a load at (ld_s, ld_t) and a 10-cycle disable after (dis_s, dis_t).
   task automatic check_frame(input int ld_s, input int ld_t, input logic [15:0] ld_v,
                              input logic [3:0] ld_m, input int dis_s, input int dis_t);
      slot_t      cur[N];
      logic [3:0] ean;
      if (sbq.size() < N) begin
         chk("scoreboard_depth", sbq.size(), N);
         return;
      end
      for (int s = 0; s < N; s++) cur[s] = sbq.pop_front();
      for (int s = 0; s < N; s++) begin
         for (int t = 0; t < T; t++) begin
            if (s == ld_s && t == ld_t) begin
               load = 1'b1;
               digits_in = ld_v;
               push_frame(ld_v, ld_m);
            end
            step();
            load = 1'b0;
            if (t < G) begin
               chk($sformatf("guard_an_n s%0d t%0d", s, t), an_n, 4'hF);
               chk($sformatf("guard_blank s%0d t%0d", s, t), blank, 1);
            end else begin
               ean = ~(4'b0001 << s);
               chk($sformatf("an_n s%0d t%0d", s, t), an_n, ean);
               chk($sformatf("digit s%0d t%0d", s, t), digit, cur[s].digit);
               chk($sformatf("blank s%0d t%0d", s, t), blank, cur[s].blank);
            end
            chk($sformatf("frame_start s%0d t%0d", s, t), frame_start, (s == N-1 && t == T-1));
            if (s == dis_s && t == dis_t) begin
               enable = 1'b0;
               repeat (10) begin
                  step();
                  chk_dark("disabled");
               end
               enable = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int n;
      tab[0] = '{16'h1234, 4'b0000};
      tab[1] = '{16'h0040, 4'b1100};
      tab[2] = '{16'h0000, 4'b1110};
      tab[3] = '{16'h9ABF, 4'b0000};
      tab[4] = '{16'h0F00, 4'b1000};
      tab[5] = '{16'h0001, 4'b1110};

      // Reset held for three cycles, then the first lit slot three cycles later.
      rst = 1'b1;
      enable = 1'b1;
      repeat (3) begin
         step();
         chk_reset("reset");
      end
      rst = 1'b0;
      step();
      chk("post_reset_g0_an_n", an_n, 4'hF);
      step();
      chk("post_reset_g1_an_n", an_n, 4'hF);
      step();
      chk("post_reset_lit_an_n", an_n, 4'b1110);
      chk("post_reset_lit_blank", blank, 0);
      chk("post_reset_lit_digit", digit, 0);

      // Table-driven frames: load, wait for the wrap, scan one frame.
      for (int i = 0; i < 6; i++) begin
         do_load(tab[i].val, tab[i].lzb);
         wait_fs(n);
         if (i > 0) chk($sformatf("frame_period %0d", i), n, 31);
         check_frame(-1, -1, 16'h0, 4'h0, -1, -1);
      end

      // Load mid-frame at idx=1: old frame completes, new one follows.
      do_load(16'h1234, 4'b0000);
      wait_fs(n);
      chk("frame_period_1234", n, 31);
      check_frame(1, 3, 16'h5678, 4'b0000, -1, -1);
      // Disable at idx=2 tick=5 for 10 cycles; scan resumes where it froze.
      check_frame(-1, -1, 16'h0, 4'h0, 2, 4);

      // Load while disabled; transfer waits for the next wrap after re-enable.
      enable = 1'b0;
      do_load(16'h0042, 4'b1100);
      repeat (20) begin
         step();
         chk_dark("disabled_load");
      end
      enable = 1'b1;
      wait_fs(n);
      chk("frame_period_after_disable", n, 32);
      // Load exactly on the wrap edge goes straight to the display.
      check_frame(3, 7, 16'h0300, 4'b1000, -1, -1);
      check_frame(-1, -1, 16'h0, 4'h0, -1, -1);

      // Reset mid-scan with a pending load: pending discarded, shadow cleared.
      load = 1'b1;
      digits_in = 16'h7777;
      step();
      load = 1'b0;
      repeat (18) step();
      rst = 1'b1;
      step();
      chk_reset("midscan_reset");
      rst = 1'b0;
      step();
      chk("restart_g0_an_n", an_n, 4'hF);
      step();
      chk("restart_g1_an_n", an_n, 4'hF);
      step();
      chk("restart_lit_an_n", an_n, 4'b1110);
      chk("restart_lit_digit", digit, 0);
      chk("restart_lit_blank", blank, 0);
      push_frame(16'h0000, 4'b1110);
      wait_fs(n);
      chk("restart_frame_period", n, 29);
      check_frame(-1, -1, 16'h0, 4'h0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
